sprite_compositor: RTL and testbench

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

---
 rtl/sprite_compositor.sv | 154 +++++++++++++++
 tb/tb_sprite_compositor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// Purpose: composites a keyed sprite over a background pixel stream and
//          generates the pop (sprite frame select) animation toggle.
// Latency: SPRITE_LATENCY+1 pixel_clk cycles for colour, timing and counts;
//          pop is registered one cycle after the qualifying new_frame.
// Backpressure: none; a free-running video stream, one pixel per cycle.
//
// Ports:
//   pixel_clk, rst             sole clock, synchronous active-high reset
//   h/v_count_in, *sync_in,    timing aligned with the sprite stage address
//   active_in, bg_*
//   spr_*                      sprite RGB, SPRITE_LATENCY cycles after counts
//   new_frame, pop_en          frame pulse and animation enable
//   pop                        sprite frame select back to the sprite stage
//   red/green/blue, *_out      composited pixel with matching delayed timing
module sprite_compositor #(
    parameter int          SPRITE_LATENCY = 4,
    parameter logic [23:0] KEY_COLOR      = 24'h000000,
    parameter int          POP_FRAMES     = 30
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [10:0] h_count_in,
    input  logic [9:0]  v_count_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        active_in,
    input  logic        new_frame,
    input  logic        pop_en,
    input  logic [7:0]  bg_red,
    input  logic [7:0]  bg_green,
    input  logic [7:0]  bg_blue,
    input  logic [7:0]  spr_red,
    input  logic [7:0]  spr_green,
    input  logic [7:0]  spr_blue,
    output logic        pop,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        active_out,
    output logic [10:0] h_count_out,
    output logic [9:0]  v_count_out
);

    // One delay-line word: {hsync, vsync, active, h_count, v_count, bg rgb}
    localparam int STAGE_W = 3 + 11 + 10 + 24;
    localparam logic [7:0] LAST_FRAME = 8'(POP_FRAMES - 1);

    logic [STAGE_W-1:0] r_pipe [SPRITE_LATENCY];
    logic [STAGE_W-1:0] w_stage_in;
    logic [STAGE_W-1:0] w_tail;

    logic        w_d_hs;
    logic        w_d_vs;
    logic        w_d_act;
    logic [10:0] w_d_h;
    logic [9:0]  w_d_v;
    logic [23:0] w_d_bg;
    logic [23:0] w_spr;
    logic [23:0] w_rgb;

    logic [23:0] r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_act;
    logic [10:0] r_h;
    logic [9:0]  r_v;
    logic [7:0]  r_frame_cnt;
    logic        r_pop;

    assign w_stage_in = {hsync_in, vsync_in, active_in, h_count_in, v_count_in,
                         bg_red, bg_green, bg_blue};

    // The last stage lines up with the sprite RGB that the two BRAM reads
    // return for the same h/v count.
    assign w_tail = r_pipe[SPRITE_LATENCY-1];
    assign {w_d_hs, w_d_vs, w_d_act, w_d_h, w_d_v, w_d_bg} = w_tail;
    assign w_spr = {spr_red, spr_green, spr_blue};

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            for (int i = 0; i < SPRITE_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_stage_in;
            for (int i = 1; i < SPRITE_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Blanking wins over everything; the key colour shows the background.
    always_comb begin
        w_rgb = 24'h000000;
        if (!w_d_act) begin
            w_rgb = 24'h000000;
        end else if (w_spr == KEY_COLOR) begin
            w_rgb = w_d_bg;
        end else begin
            w_rgb = w_spr;
        end
    end

    // Colour and timing share one register so they leave with no skew.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_rgb <= '0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
            r_act <= 1'b0;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            r_rgb <= w_rgb;
            r_hs  <= w_d_hs;
            r_vs  <= w_d_vs;
            r_act <= w_d_act;
            r_h   <= w_d_h;
            r_v   <= w_d_v;
        end
    end

    // Pop animation: pop_en low holds everything cleared, even against a
    // coincident new_frame, so pop can only move on a frame boundary.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_pop       <= 1'b0;
        end else if (!pop_en) begin
            r_frame_cnt <= '0;
            r_pop       <= 1'b0;
        end else if (new_frame) begin
            if (r_frame_cnt == LAST_FRAME) begin
                r_frame_cnt <= '0;
                r_pop       <= ~r_pop;
            end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign pop         = r_pop;
    assign red         = r_rgb[23:16];
    assign green       = r_rgb[15:8];
    assign blue        = r_rgb[7:0];
    assign hsync_out   = r_hs;
    assign vsync_out   = r_vs;
    assign active_out  = r_act;
    assign h_count_out = r_h;
    assign v_count_out = r_v;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench: the driver pushes hand-computed expected outputs tagged
// with the cycle they are due; a negedge monitor pops and compares them.
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] h_count_in;
    logic [9:0]  v_count_in;
    logic        hsync_in, vsync_in, active_in, new_frame, pop_en;
    logic [7:0]  bg_red, bg_green, bg_blue, spr_red, spr_green, spr_blue;
    logic        pop;
    logic [7:0]  red, green, blue;
    logic        hsync_out, vsync_out, active_out;
    logic [10:0] h_count_out;
    logic [9:0]  v_count_out;

    always #5 clk = ~clk;

    sprite_compositor #(
        .SPRITE_LATENCY(4),
        .KEY_COLOR     (24'h000000),
        .POP_FRAMES    (3)
    ) dut (
        .pixel_clk  (clk),
        .rst        (rst),
        .h_count_in (h_count_in),
        .v_count_in (v_count_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .active_in  (active_in),
        .new_frame  (new_frame),
        .pop_en     (pop_en),
        .bg_red     (bg_red),
        .bg_green   (bg_green),
        .bg_blue    (bg_blue),
        .spr_red    (spr_red),
        .spr_green  (spr_green),
        .spr_blue   (spr_blue),
        .pop        (pop),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .active_out (active_out),
        .h_count_out(h_count_out),
        .v_count_out(v_count_out)
    );

    typedef struct {
        logic        act, hs, vs;
        logic [10:0] h;
        logic [9:0]  v;
        logic [23:0] bg, spr, exp_rgb;
    } vec_t;

    typedef struct {
        int          due;
        logic [23:0] rgb;
        logic        hs, vs, act;
        logic [10:0] h;
        logic [9:0]  v;
    } exp_t;

    typedef struct {
        int   due;
        logic pop;
    } pexp_t;

    exp_t        sb[$];
    pexp_t       psb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [23:0] spr_hist [4];
    exp_t        mon_e;
    pexp_t       mon_p;
    vec_t        vt [10];
    logic [45:0] got_px, want_px;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due at this edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            got_px  = {red, green, blue, hsync_out, vsync_out, active_out, h_count_out, v_count_out};
            want_px = {mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.act, mon_e.h, mon_e.v};
            if (mon_e.due != cyc) begin
                n_fail++;
                $display("FAIL pixel_missed: due cycle %0d, now %0d", mon_e.due, cyc);
            end else if (got_px !== want_px) begin
                n_fail++;
                $display("FAIL pixel @%0d: got rgb=%06h hs=%b vs=%b act=%b h=%0d v=%0d, want rgb=%06h hs=%b vs=%b act=%b h=%0d v=%0d",
                         cyc, {red, green, blue}, hsync_out, vsync_out, active_out, h_count_out, v_count_out,
                         mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.act, mon_e.h, mon_e.v);
            end
        end
        while (psb.size() > 0 && psb[0].due <= cyc) begin
            mon_p = psb.pop_front();
            n_checks++;
            if (mon_p.due != cyc || pop !== mon_p.pop) begin
                n_fail++;
                $display("FAIL pop @%0d (due %0d): got %b, want %b", cyc, mon_p.due, pop, mon_p.pop);
            end
        end
    end

    function automatic vec_t mk(input logic act, hs, vs, input int h, v,
                                input logic [23:0] bg, spr, exp_rgb);
        vec_t r;
        r.act = act; r.hs = hs; r.vs = vs;
        r.h = 11'(h); r.v = 10'(v);
        r.bg = bg; r.spr = spr; r.exp_rgb = exp_rgb;
        return r;
    endfunction

    // One pixel per cycle; the sprite colour for a vector goes out 4 cycles
    // after its counts, and its output is due 5 edges after it is sampled.
    task automatic drive_vec(input vec_t v);
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b0; new_frame = 1'b0; pop_en = 1'b0;
        active_in = v.act; hsync_in = v.hs; vsync_in = v.vs;
        h_count_in = v.h; v_count_in = v.v;
        {bg_red, bg_green, bg_blue} = v.bg;
        {spr_red, spr_green, spr_blue} = spr_hist[3];
        for (int i = 3; i > 0; i--) spr_hist[i] = spr_hist[i-1];
        spr_hist[0] = v.spr;
        e.due = cyc + 5; e.rgb = v.exp_rgb;
        e.hs = v.hs; e.vs = v.vs; e.act = v.act; e.h = v.h; e.v = v.v;
        sb.push_back(e);
    endtask

    // Reset cycle: in-flight pixels are discarded, outputs read zero on the
    // reset edge and for the refill cycles that follow.
    task automatic do_reset();
        exp_t  e;
        pexp_t p;
        @(posedge clk); #1;
        rst = 1'b1; new_frame = 1'b0; pop_en = 1'b0;
        while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
        while (psb.size() > 0 && psb[psb.size()-1].due > cyc) void'(psb.pop_back());
        for (int i = 0; i < 4; i++) spr_hist[i] = 24'h0;
        for (int i = 1; i <= 5; i++) begin
            e = '{default: '0};
            e.due = cyc + i;
            sb.push_back(e);
        end
        p.due = cyc + 1; p.pop = 1'b0;
        psb.push_back(p);
        // All-zero pixel sampled on release: the sixth zero output.
        drive_vec(mk(0, 0, 0, 0, 0, 24'h0, 24'h0, 24'h0));
    endtask

    task automatic pop_step(input logic en, input logic nf, input logic want);
        pexp_t p;
        @(posedge clk); #1;
        pop_en = en; new_frame = nf;
        p.due = cyc + 1; p.pop = want;
        psb.push_back(p);
    endtask

    initial begin
        rst = 1'b1; h_count_in = '0; v_count_in = '0;
        hsync_in = 0; vsync_in = 0; active_in = 0; new_frame = 0; pop_en = 0;
        {bg_red, bg_green, bg_blue} = 24'h0;
        {spr_red, spr_green, spr_blue} = 24'h0;
        for (int i = 0; i < 4; i++) spr_hist[i] = 24'h0;

        vt[0] = mk(1, 0, 0,  10, 5, 24'h102030, 24'hFF0000, 24'hFF0000);
        vt[1] = mk(1, 0, 0,  11, 5, 24'h405060, 24'h000000, 24'h405060);
        vt[2] = mk(0, 0, 0,  12, 5, 24'h405060, 24'h000000, 24'h000000);
        vt[3] = mk(1, 1, 0, 100, 6, 24'h0A0B0C, 24'h123456, 24'h123456);
        vt[4] = mk(0, 0, 1, 101, 7, 24'hFFFFFF, 24'hFFFFFF, 24'h000000);
        vt[5] = mk(1, 0, 0, 102, 7, 24'h777777, 24'h000001, 24'h000001);
        vt[6] = mk(1, 0, 0, 103, 7, 24'h808080, 24'h010000, 24'h010000);
        vt[7] = mk(1, 0, 0, 2047, 1023, 24'hABCDEF, 24'h000000, 24'hABCDEF);
        vt[8] = mk(1, 1, 1, 0, 0, 24'h123123, 24'hFEDCBA, 24'hFEDCBA);
        vt[9] = mk(0, 0, 0, 0, 0, 24'h0, 24'h0, 24'h0);

        do_reset();
        for (int i = 0; i < 9; i++) drive_vec(vt[i]);
        // Mid-line reset with pixels still in the delay line.
        do_reset();
        for (int i = 0; i < 9; i++) drive_vec(vt[i]);
        for (int i = 0; i < 6; i++) drive_vec(vt[9]);

        pop_step(1, 0, 0);
        pop_step(1, 1, 0);  // 1
        pop_step(1, 0, 0);
        pop_step(1, 1, 0);  // 2
        pop_step(1, 0, 0);
        pop_step(1, 1, 1);  // 3 toggles
        pop_step(1, 0, 1);
        pop_step(1, 1, 1);  // 4
        pop_step(1, 0, 1);
        pop_step(1, 1, 1);  // 5
        pop_step(1, 0, 1);
        pop_step(1, 1, 0);  // 6 toggles
        pop_step(1, 0, 0);
        pop_step(1, 1, 0);  // 7
        pop_step(1, 1, 0);
        pop_step(1, 1, 1);  // wrap, pop=1
        pop_step(1, 0, 1);
        pop_step(0, 1, 0);  // disable beats new_frame
        pop_step(0, 1, 0);  // ignored while disabled
        pop_step(0, 0, 0);
        pop_step(1, 1, 0);  // counter restarted from 0
        pop_step(1, 1, 0);
        pop_step(1, 1, 1);

        for (int i = 0; i < 20 && (sb.size() > 0 || psb.size() > 0); i++) @(posedge clk);
        @(negedge clk); #1;
        if (sb.size() > 0 || psb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d pixel and %0d pop expectations never checked", sb.size(), psb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
